// File: rtl/key_debounce_module.sv
// -----------------------------------------------------------------------------
// key_debounce_module
//
// Purpose:
//   Cleans up one raw, bouncing, active-low push-button pin sampled on the
//   system clock. The pin is brought into the clock domain by a two-flop
//   synchronizer. A four-state FSM then confirms a level change only after
//   the synchronized pin has held the new value for a full debounce window.
//   A hold counter measures how long a confirmed press lasts and raises a
//   single long-press strobe once the hold time is reached.
//
// Parameters:
//   T_DEB    debounce window in clock cycles (>= 2)
//   T_LONG   hold time from Press_Pulse to Long_Pulse in cycles (>= 2)
//   CW_DEB   debounce counter width, 2**CW_DEB > T_DEB
//   CW_LONG  hold counter width, 2**CW_LONG > T_LONG
//
// Ports:
//   CLK            in   system clock, the only clock
//   RST            in   synchronous, active-high reset
//   KEY_In         in   raw button pin, asynchronous, 0 = pressed
//   Key_Level      out  debounced state, 1 = pressed
//   Press_Pulse    out  one-cycle strobe on each confirmed press
//   Release_Pulse  out  one-cycle strobe on each confirmed release
//   Long_Pulse     out  one-cycle strobe, once per press held T_LONG cycles
// -----------------------------------------------------------------------------
module key_debounce_module #(
   parameter int unsigned T_DEB   = 500_000,
   parameter int unsigned T_LONG  = 50_000_000,
   parameter int unsigned CW_DEB  = 19,
   parameter int unsigned CW_LONG = 26
) (
   input  logic CLK,
   input  logic RST,
   input  logic KEY_In,
   output logic Key_Level,
   output logic Press_Pulse,
   output logic Release_Pulse,
   output logic Long_Pulse
);

   localparam logic [CW_DEB-1:0]  DEB_LAST  = CW_DEB'(T_DEB - 1);
   localparam logic [CW_LONG-1:0] LONG_MAX  = CW_LONG'(T_LONG);
   localparam logic [CW_LONG-1:0] LONG_LAST = CW_LONG'(T_LONG - 1);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_FILT_DN = 2'd1,
      ST_DOWN    = 2'd2,
      ST_FILT_UP = 2'd3
   } state_t;

   // Hold counter step that parks at T_LONG instead of wrapping, so a
   // button held indefinitely can never produce a second long-press strobe.
   function automatic logic [CW_LONG-1:0] hold_sat_inc(input logic [CW_LONG-1:0] v);
      return (v < LONG_MAX) ? (v + CW_LONG'(1)) : v;
   endfunction

   // Debounce counter step; the FSM never lets it run past DEB_LAST.
   function automatic logic [CW_DEB-1:0] deb_inc(input logic [CW_DEB-1:0] v);
      return v + CW_DEB'(1);
   endfunction

   // ------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------
   logic                sync1_q;
   logic                key_s_q;
   state_t              state_q;
   logic [CW_DEB-1:0]   dcnt_q;
   logic [CW_LONG-1:0]  hcnt_q;
   logic                key_level_q;
   logic                press_q;
   logic                release_q;
   logic                long_q;

   // Next-state helpers
   logic                deb_done_d;
   logic                rel_confirm_d;
   logic                hold_active_d;
   logic                long_fire_d;
   logic [CW_DEB-1:0]   dcnt_inc_d;
   logic [CW_LONG-1:0]  hcnt_d;

   // ------------------------------------------------------------------
   // Synchronizer: both flops idle at 1 (released, pull-up level).
   // ------------------------------------------------------------------
   always_ff @(posedge CLK) begin
      if (RST) begin
         sync1_q <= 1'b1;
         key_s_q <= 1'b1;
      end else begin
         sync1_q <= KEY_In;
         key_s_q <= sync1_q;
      end
   end

   // ------------------------------------------------------------------
   // Counter control
   // ------------------------------------------------------------------
   always_comb begin
      deb_done_d    = (dcnt_q == DEB_LAST);
      dcnt_inc_d    = deb_inc(dcnt_q);

      // A release confirmed on this edge wins over the hold counter, so a
      // release landing on the same edge as the long-press suppresses it.
      rel_confirm_d = (state_q == ST_FILT_UP) && key_s_q && deb_done_d;

      // The key counts as held in DOWN and while a release is still being
      // filtered; bounces that do not confirm a release keep it counting.
      hold_active_d = ((state_q == ST_DOWN) || (state_q == ST_FILT_UP)) && !rel_confirm_d;

      hcnt_d        = hold_active_d ? hold_sat_inc(hcnt_q) : hcnt_q;

      // Only the T_LONG-1 -> T_LONG step fires; saturation prevents repeats.
      long_fire_d   = hold_active_d && (hcnt_q == LONG_LAST);
   end

   // ------------------------------------------------------------------
   // Debounce FSM with registered outputs
   // ------------------------------------------------------------------
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q     <= ST_IDLE;
         dcnt_q      <= '0;
         hcnt_q      <= '0;
         key_level_q <= 1'b0;
         press_q     <= 1'b0;
         release_q   <= 1'b0;
         long_q      <= 1'b0;
      end else begin
         press_q   <= 1'b0;
         release_q <= 1'b0;
         long_q    <= long_fire_d;
         hcnt_q    <= hcnt_d;

         case (state_q)
            ST_IDLE: begin
               key_level_q <= 1'b0;
               if (!key_s_q) begin
                  state_q <= ST_FILT_DN;
                  dcnt_q  <= '0;
               end
            end

            ST_FILT_DN: begin
               if (key_s_q) begin
                  state_q <= ST_IDLE;
                  dcnt_q  <= '0;
               end else if (deb_done_d) begin
                  state_q     <= ST_DOWN;
                  key_level_q <= 1'b1;
                  press_q     <= 1'b1;
                  hcnt_q      <= '0;
               end else begin
                  dcnt_q <= dcnt_inc_d;
               end
            end

            ST_DOWN: begin
               key_level_q <= 1'b1;
               if (key_s_q) begin
                  state_q <= ST_FILT_UP;
                  dcnt_q  <= '0;
               end
            end

            ST_FILT_UP: begin
               // Pin low again cancels the release even on the final
               // filter cycle; the hold count carries on untouched.
               if (!key_s_q) begin
                  state_q <= ST_DOWN;
                  dcnt_q  <= '0;
               end else if (deb_done_d) begin
                  state_q     <= ST_IDLE;
                  key_level_q <= 1'b0;
                  release_q   <= 1'b1;
               end else begin
                  dcnt_q <= dcnt_inc_d;
               end
            end

            default: begin
               state_q     <= ST_IDLE;
               dcnt_q      <= '0;
               key_level_q <= 1'b0;
            end
         endcase
      end
   end

   assign Key_Level     = key_level_q;
   assign Press_Pulse   = press_q;
   assign Release_Pulse = release_q;
   assign Long_Pulse    = long_q;

endmodule

// File: tb/tb_key_debounce_module.sv
// -----------------------------------------------------------------------------
// tb_key_debounce_module
//
// Directed stimulus for key_debounce_module with T_DEB=4, T_LONG=20.
// A behavioural model (run-length of synchronized samples that disagree
// with the debounced level, plus cycles held since the press) is compared
// with the DUT outputs on every falling edge. Hand-computed edge numbers
// pin the model for each scenario.
// -----------------------------------------------------------------------------
module tb_key_debounce_module;

   localparam int TD = 4;
   localparam int TL = 20;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic key = 1'b1;
   logic lvl, pp, rp, lp;

   key_debounce_module #(
      .T_DEB   (TD),
      .T_LONG  (TL),
      .CW_DEB  (3),
      .CW_LONG (5)
   ) dut (
      .CLK           (clk),
      .RST           (rst),
      .KEY_In        (key),
      .Key_Level     (lvl),
      .Press_Pulse   (pp),
      .Release_Pulse (rp),
      .Long_Pulse    (lp)
   );

   always #10 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
   endtask

   // ------------------------------------------------------------------
   // Behavioural model
   // ------------------------------------------------------------------
   bit m_s1 = 1'b1, m_s2 = 1'b1;
   int m_run = 0, m_hold = 0;
   bit m_lvl = 1'b0, m_p = 1'b0, m_r = 1'b0, m_l = 1'b0;
   bit m_valid = 1'b0;

   always @(posedge clk) begin : model
      bit ks;
      bit want;
      m_p = 1'b0; m_r = 1'b0; m_l = 1'b0;
      if (rst) begin
         m_s1 = 1'b1; m_s2 = 1'b1;
         m_run = 0; m_hold = 0; m_lvl = 1'b0;
      end else begin
         ks   = m_s2;
         m_s2 = m_s1;
         m_s1 = key;
         want = !ks;
         if (want != m_lvl) m_run++;
         else m_run = 0;
         if (m_run == TD + 1) begin
            m_run = 0;
            m_lvl = want;
            if (want) begin m_p = 1'b1; m_hold = 0; end
            else m_r = 1'b1;
         end else if (m_lvl && m_hold < TL) begin
            m_hold++;
            if (m_hold == TL) m_l = 1'b1;
         end
      end
      m_valid = 1'b1;
   end

   // ------------------------------------------------------------------
   // Compare and pulse observation
   // ------------------------------------------------------------------
   int press_cnt = 0, rel_cnt = 0, long_cnt = 0;
   int press_e = -1, rel_e = -1, long_e = -1;

   always @(negedge clk) begin
      if (m_valid) begin
         chk("Key_Level",     lvl, m_lvl);
         chk("Press_Pulse",   pp,  m_p);
         chk("Release_Pulse", rp,  m_r);
         chk("Long_Pulse",    lp,  m_l);
      end
      if (pp === 1'b1) begin press_cnt++; press_e = cyc; end
      if (rp === 1'b1) begin rel_cnt++;   rel_e   = cyc; end
      if (lp === 1'b1) begin long_cnt++;  long_e  = cyc; end
   end

   // Clear observations on a rising edge (monitor runs on falling edges),
   // then return to a falling edge for driving.
   task automatic clr_obs();
      @(posedge clk);
      press_cnt = 0; rel_cnt = 0; long_cnt = 0;
      press_e = -1;  rel_e = -1;  long_e = -1;
      @(negedge clk);
   endtask

   task automatic wait_n(input int n);
      repeat (n) @(negedge clk);
   endtask

   int e0, r;
   int pat_val [4] = '{0, 1, 0, 1};
   int pat_len [4] = '{3, 1, 2, 5};

   initial begin
      rst = 1'b1; key = 1'b1;
      wait_n(3);
      chk("rst_level",   lvl, 0);
      chk("rst_press",   pp,  0);
      chk("rst_release", rp,  0);
      chk("rst_long",    lp,  0);
      rst = 1'b0;
      wait_n(3);

      // Clean press followed by long press
      clr_obs();
      key = 1'b0; e0 = cyc + 1;
      wait_n(32);
      chk("press_edge",  press_e - e0, 6);
      chk("press_count", press_cnt, 1);
      chk("long_edge",   long_e - e0, 26);
      chk("long_count",  long_cnt, 1);
      chk("no_release",  rel_cnt, 0);

      // Clean release after long press
      clr_obs();
      key = 1'b1; r = cyc + 1;
      wait_n(10);
      chk("release_edge",  rel_e - r, 6);
      chk("release_count", rel_cnt, 1);
      chk("rel_no_long",   long_cnt, 0);
      chk("rel_no_press",  press_cnt, 0);

      // Short press released before the long-press time
      clr_obs();
      key = 1'b0; e0 = cyc + 1;
      wait_n(10);
      key = 1'b1;
      wait_n(30);
      chk("short_press_edge", press_e - e0, 6);
      chk("short_rel_edge",   rel_e - e0, 16);
      chk("short_no_long",    long_cnt, 0);

      // Bounce rejection
      clr_obs();
      for (int i = 0; i < 4; i++) begin
         key = pat_val[i][0];
         wait_n(pat_len[i]);
      end
      wait_n(5);
      chk("bounce_no_press", press_cnt, 0);
      chk("bounce_level",    lvl, 0);
      key = 1'b0; e0 = cyc + 1;
      wait_n(10);
      key = 1'b1;
      wait_n(12);
      chk("bounce_then_press", press_cnt, 1);
      chk("bounce_press_edge", press_e - e0, 6);
      chk("bounce_release",    rel_cnt, 1);

      // Release bounce: high 3, low 1, still held
      clr_obs();
      key = 1'b0; e0 = cyc + 1;
      wait_n(8);
      key = 1'b1;
      wait_n(3);
      key = 1'b0;
      wait_n(26);
      chk("rb_no_release", rel_cnt, 0);
      chk("rb_long_delay", long_e - press_e, 20);
      chk("rb_long_count", long_cnt, 1);
      chk("rb_level",      lvl, 1);

      // Release cancelled in the final filter cycle
      clr_obs();
      key = 1'b1;
      wait_n(4);
      key = 1'b0;
      wait_n(8);
      chk("cancel_no_release", rel_cnt, 0);
      chk("cancel_level",      lvl, 1);
      chk("cancel_no_long",    long_cnt, 0);
      key = 1'b1;
      wait_n(10);

      // Release confirmed on the same edge the long press would fire
      clr_obs();
      key = 1'b0; e0 = cyc + 1;
      wait_n(20);
      key = 1'b1;
      wait_n(12);
      chk("tie_release_edge", rel_e - e0, 26);
      chk("tie_no_long",      long_cnt, 0);

      // Reset while held
      clr_obs();
      key = 1'b0; e0 = cyc + 1;
      wait_n(12);
      rst = 1'b1;
      wait_n(1);
      chk("mid_rst_level", lvl, 0);
      rst = 1'b0;
      wait_n(1);
      chk("post_rst_level", lvl, 0);
      chk("post_rst_press", pp, 0);
      wait_n(10);
      chk("rerun_press_count", press_cnt, 2);
      chk("rerun_press_edge",  press_e - e0, 19);
      chk("rerun_no_release",  rel_cnt, 0);
      key = 1'b1;
      wait_n(12);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
